// File: rtl/axi_rdata_pkg.sv
// Shared definitions for the read-data return router: response code,
// burst framing states and one-hot tag helpers.
package axi_rdata_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    // Upper bound on the master count the tag helpers can handle.
    localparam int         MAX_MASTERS = 32;
    localparam int         IDX_W       = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_t;

    // True when exactly one bit of the (zero-extended) tag is set.
    function automatic logic onehot_legal(input logic [MAX_MASTERS-1:0] vec);
        return (vec != '0) &&
               ((vec & (vec - {{(MAX_MASTERS-1){1'b0}}, 1'b1})) == '0);
    endfunction

    // Position of the set bit of a legal one-hot tag.
    function automatic logic [IDX_W-1:0] onehot_index(input logic [MAX_MASTERS-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_rdata_router_rslice.sv
// One-entry register slice for a single master's R channel, plus the
// burst framing tracker that catches ID interleave inside a burst.
module axi_rslice
    import axi_rdata_pkg::*;
#(
    parameter int id_bits    = 2,
    parameter int data_width = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [id_bits-1:0]    beat_id,
    input  logic [data_width-1:0] beat_data,
    input  logic                  beat_last,
    input  logic                  r_ready,
    output logic                  space,
    output logic                  id_error,
    output logic                  r_valid,
    output logic [id_bits-1:0]    r_id,
    output logic [data_width-1:0] r_data,
    output logic                  r_last
);

    burst_state_t       state;
    logic [id_bits-1:0] burst_id;

    // The slot can take a beat when empty or when it drains this cycle,
    // which gives one beat per cycle with no bubble.
    assign space    = !r_valid || r_ready;
    assign id_error = load && (state == BURST) && (beat_id != burst_id);

    // Slot storage: load wins over drain, drain alone empties the slot.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the payload is cleared on reset as well as the valid bit,
            // so stale data never shows up on R_DATA after a reset.
            r_valid <= 1'b0;
            r_id    <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_id    <= beat_id;
            r_data  <= beat_data;
            r_last  <= beat_last;
        end else if (r_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Burst framing: remember the ID of an open burst until its LAST beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            burst_id <= '0;
        end else if (load) begin
            case (state)
                IDLE: begin
                    if (!beat_last) begin
                        state    <= BURST;
                        burst_id <= beat_id;
                    end
                end
                BURST: begin
                    if (beat_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi_rdata_router.sv
// Return-path demux: routes one-hot tagged read beats to per-master R
// channels through independent register slices, drops badly tagged beats
// and reports framing errors.
module axi_rdata_router
    import axi_rdata_pkg::*;
#(
    parameter int masters    = 4,
    parameter int id_bits    = 2,
    parameter int data_width = 64
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [masters-1:0]            MASTER,
    input  logic [id_bits-1:0]            ID,
    input  logic [data_width-1:0]         DATA,
    input  logic                          LAST,
    input  logic                          VALID,
    output logic                          READY,
    output logic [masters*id_bits-1:0]    R_ID,
    output logic [masters*data_width-1:0] R_DATA,
    output logic [masters*2-1:0]          R_RESP,
    output logic [masters-1:0]            R_LAST,
    output logic [masters-1:0]            R_VALID,
    input  logic [masters-1:0]            R_READY,
    output logic                          ERR_PULSE,
    output logic [15:0]                   DROP_COUNT
);

    logic [MAX_MASTERS-1:0] tag_pad;
    logic [MAX_MASTERS-1:0] space_pad;
    logic [IDX_W-1:0]       tag_idx;
    logic                   tag_legal;
    logic [masters-1:0]     space;
    logic [masters-1:0]     load;
    logic [masters-1:0]     id_error;
    logic                   ready;
    logic                   accept;
    logic                   drop;
    logic                   err_q;
    logic [15:0]            drop_q;

    assign tag_pad   = MAX_MASTERS'(MASTER);
    assign space_pad = MAX_MASTERS'(space);
    assign tag_legal = onehot_legal(tag_pad);
    assign tag_idx   = onehot_index(tag_pad);

    // Ready depends only on the target slot's state and R_READY; bad tags
    // are always swallowed so they cannot wedge the return path.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        ready = 1'b0;
        if (RESET)           ready = 1'b0;
        else if (!tag_legal) ready = 1'b1;
        else                 ready = space_pad[tag_idx];
    end

    assign READY  = ready;
    assign accept = VALID && ready;
    assign drop   = accept && !tag_legal;
    assign load   = {masters{accept && tag_legal}} & MASTER;
    assign R_RESP = {masters{RESP_OKAY}};

    genvar g;
    generate
        for (g = 0; g < masters; g++) begin : g_slice
            axi_rslice #(
                .id_bits    (id_bits),
                .data_width (data_width)
            ) u_slice (
                .clk       (CLK),
                .reset     (RESET),
                .load      (load[g]),
                .beat_id   (ID),
                .beat_data (DATA),
                .beat_last (LAST),
                .r_ready   (R_READY[g]),
                .space     (space[g]),
                .id_error  (id_error[g]),
                .r_valid   (R_VALID[g]),
                .r_id      (R_ID[g*id_bits +: id_bits]),
                .r_data    (R_DATA[g*data_width +: data_width]),
                .r_last    (R_LAST[g])
            );
        end
    endgenerate

    // Error pulse and saturating drop counter, both registered.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            err_q <= drop || (|id_error);
            if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
        end
    end

    assign ERR_PULSE  = err_q;
    assign DROP_COUNT = drop_q;

endmodule

// File: tb/tb_axi_rdata_router.sv
// Self-checking bench for axi_rdata_router: a behavioural model predicts
// READY, slot occupancy, error pulses and drop count every cycle, and
// per-master queues hold the beats each R channel must deliver in order.
module tb_axi_rdata_router;

    localparam int M  = 4;
    localparam int IB = 2;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [M-1:0]    master;
    logic [IB-1:0]   id;
    logic [DW-1:0]   data;
    logic            last;
    logic            valid;
    logic            ready;
    logic [M*IB-1:0] r_id;
    logic [M*DW-1:0] r_data;
    logic [M*2-1:0]  r_resp;
    logic [M-1:0]    r_last;
    logic [M-1:0]    r_valid;
    logic [M-1:0]    r_ready;
    logic            err_pulse;
    logic [15:0]     drop_count;

    axi_rdata_router #(
        .masters    (M),
        .id_bits    (IB),
        .data_width (DW)
    ) dut (
        .CLK        (clk),
        .RESET      (reset),
        .MASTER     (master),
        .ID         (id),
        .DATA       (data),
        .LAST       (last),
        .VALID      (valid),
        .READY      (ready),
        .R_ID       (r_id),
        .R_DATA     (r_data),
        .R_RESP     (r_resp),
        .R_LAST     (r_last),
        .R_VALID    (r_valid),
        .R_READY    (r_ready),
        .ERR_PULSE  (err_pulse),
        .DROP_COUNT (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IB-1:0] id;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         sb [M][$];
    logic [M-1:0]  m_valid;
    logic          m_burst [M];
    logic [IB-1:0] m_bid [M];
    logic [15:0]   m_drop;
    logic          m_err;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = '0;
        m_drop  = '0;
        m_err   = 1'b0;
        for (int m = 0; m < M; m++) begin
            m_burst[m] = 1'b0;
            m_bid[m]   = '0;
            sb[m].delete();
        end
    endtask

    // One clock: check combinational/registered outputs before the edge,
    // advance the model, then check registered status after the edge.
    task automatic tick();
        logic  legal;
        int    idx;
        logic  exp_ready;
        logic  nerr;
        beat_t e;
        #1;
        legal = ($countones(master) == 1);
        idx   = 0;
        for (int m = 0; m < M; m++) if (master[m]) idx = m;
        if (reset)       exp_ready = 1'b0;
        else if (!legal) exp_ready = 1'b1;
        else             exp_ready = !m_valid[idx] || r_ready[idx];

        check("ready", 64'(ready), 64'(exp_ready));
        check("r_valid", 64'(r_valid), 64'(m_valid));
        check("r_resp", 64'(r_resp), 64'(0));

        for (int m = 0; m < M; m++) begin
            if (r_valid[m] && r_ready[m]) begin
                if (sb[m].size() == 0) begin
                    check("sb_underflow", 64'(sb[m].size()), 64'(1));
                end else begin
                    e = sb[m].pop_front();
                    check("r_id",   64'(r_id[m*IB +: IB]), 64'(e.id));
                    check("r_data", r_data[m*DW +: DW],    e.data);
                    check("r_last", 64'(r_last[m]),        64'(e.last));
                end
            end
        end

        if (reset) begin
            model_reset();
        end else begin
            nerr = 1'b0;
            for (int m = 0; m < M; m++) if (m_valid[m] && r_ready[m]) m_valid[m] = 1'b0;
            if (valid && exp_ready) begin
                if (legal) begin
                    m_valid[idx] = 1'b1;
                    sb[idx].push_back('{id: id, data: data, last: last});
                    if (m_burst[idx]) begin
                        if (id != m_bid[idx]) nerr = 1'b1;
                        if (last) m_burst[idx] = 1'b0;
                    end else if (!last) begin
                        m_burst[idx] = 1'b1;
                        m_bid[idx]   = id;
                    end
                end else begin
                    nerr = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end
            end
            m_err = nerr;
        end

        @(posedge clk);
        @(negedge clk);
        check("err_pulse", 64'(err_pulse), 64'(m_err));
        check("drop_count", 64'(drop_count), 64'(m_drop));
    endtask

    task automatic set_beat(input logic [M-1:0] mst, input logic [IB-1:0] i,
                            input logic [DW-1:0] d, input logic l);
        master = mst;
        id     = i;
        data   = d;
        last   = l;
        valid  = 1'b1;
    endtask

    task automatic idle();
        valid  = 1'b0;
        master = '0;
    endtask

    initial begin
        model_reset();
        reset   = 1'b1;
        valid   = 1'b0;
        master  = '0;
        id      = '0;
        data    = '0;
        last    = 1'b0;
        r_ready = '1;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        check("reset_rvalid", 64'(r_valid), 64'(0));
        check("reset_drop", 64'(drop_count), 64'(0));

        // Single beat to master 2.
        set_beat(4'b0100, 2'd2, 64'hA5A5, 1'b1);
        tick();
        idle();
        check("single_rvalid", 64'(r_valid), 64'(4'b0100));
        check("single_data", r_data[2*DW +: DW], 64'hA5A5);
        check("single_last", 64'(r_last[2]), 64'(1));
        tick();

        // Backpressure on master 1, then drain and reload in one cycle.
        r_ready = 4'b1101;
        set_beat(4'b0010, 2'd1, 64'h1111, 1'b1);
        tick();
        set_beat(4'b0010, 2'd1, 64'h2222, 1'b1);
        tick();
        tick();
        r_ready = 4'b1111;
        tick();
        idle();
        check("nobubble_rvalid1", 64'(r_valid[1]), 64'(1));
        check("nobubble_data", r_data[1*DW +: DW], 64'h2222);
        tick();

        // Master 0 stalled full must not block master 3.
        r_ready = 4'b1110;
        set_beat(4'b0001, 2'd0, 64'h10, 1'b1);
        tick();
        set_beat(4'b1000, 2'd3, 64'h30, 1'b1);
        tick();
        idle();
        check("indep_rvalid", 64'(r_valid), 64'(4'b1001));
        tick();
        r_ready = 4'b1111;
        tick();
        tick();

        // Illegal tags: none set, two set.
        set_beat(4'b0000, 2'd0, 64'hBAD0, 1'b1);
        tick();
        set_beat(4'b0011, 2'd1, 64'hBAD1, 1'b1);
        tick();
        idle();
        check("illegal_drop2", 64'(drop_count), 64'(2));
        tick();

        // Stream bad beats until the counter saturates and stays there.
        set_beat(4'b0000, 2'd0, 64'h0, 1'b0);
        for (int n = 0; n < 65536; n++) tick();
        idle();
        check("drop_saturate", 64'(drop_count), 64'(16'hFFFF));
        tick();

        // Four-beat burst to master 0 with an interleaved ID on beat 3.
        set_beat(4'b0001, 2'd1, 64'hB0, 1'b0);
        tick();
        set_beat(4'b0001, 2'd1, 64'hB1, 1'b0);
        tick();
        set_beat(4'b0001, 2'd3, 64'hB2, 1'b0);
        tick();
        check("burst_err_beat3", 64'(err_pulse), 64'(1));
        set_beat(4'b0001, 2'd1, 64'hB3, 1'b1);
        tick();
        check("burst_noerr_beat4", 64'(err_pulse), 64'(0));
        // A fresh burst with a new ID must be clean once the FSM is idle.
        set_beat(4'b0001, 2'd2, 64'hB4, 1'b0);
        tick();
        set_beat(4'b0001, 2'd2, 64'hB5, 1'b1);
        tick();
        idle();
        tick();
        tick();

        // Reset with every slot full and a burst open on master 0.
        r_ready = 4'b0000;
        set_beat(4'b0001, 2'd1, 64'hC0, 1'b0);
        tick();
        set_beat(4'b0010, 2'd1, 64'hC1, 1'b1);
        tick();
        set_beat(4'b0100, 2'd1, 64'hC2, 1'b1);
        tick();
        set_beat(4'b1000, 2'd1, 64'hC3, 1'b1);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        r_ready = 4'b1111;
        check("midreset_rvalid", 64'(r_valid), 64'(0));
        check("midreset_drop", 64'(drop_count), 64'(0));
        set_beat(4'b0001, 2'd2, 64'hD0, 1'b1);
        tick();
        idle();
        check("post_reset_noerr", 64'(err_pulse), 64'(0));
        check("post_reset_data", r_data[0 +: DW], 64'hD0);
        tick();
        tick();

        for (int m = 0; m < M; m++) check("sb_leftover", 64'(sb[m].size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
